softmax_r2b_sequencer: RTL

Consumer-side controller for the softmax-to-R2B path of the self-attention head. It waits until every softmax row unit reports done, then reads rows back one tile column at a time. For each column it drives the row index, tile select, per-converter valid and per-converter reset to the r2b converter bank, and then releases the softmax units for the next pass. It replaces the hand-driven r2b_row_idx, in_valid_r2b and internal_rst_n_r2b_conv controls.

---
 rtl/self_attention_pkg.sv | 18 +
 rtl/softmax_r2b_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/self_attention_pkg.sv
// Shared constants and state encoding for the self-attention head's
// softmax-to-R2B control path.
package self_attention_pkg;

   localparam int TOTAL_SOFTMAX_ROW  = 16;
   localparam int TOTAL_TILE_SOFTMAX = 4;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ROWS,
      RST_R2B,
      FEED,
      DRAIN,
      RELEASE,
      DONE
   } seq_state_t;

endpackage

// File: rtl/softmax_r2b_sequencer.sv
// Reads softmax rows back one tile column at a time into the r2b converter
// bank, sequencing converter resets, row strobes and the softmax release.
module softmax_r2b_sequencer #(
   parameter int TOTAL_SOFTMAX_ROW  = self_attention_pkg::TOTAL_SOFTMAX_ROW,
   parameter int TOTAL_TILE_SOFTMAX = self_attention_pkg::TOTAL_TILE_SOFTMAX,
   parameter int ROW_IDX_W          = $clog2(TOTAL_SOFTMAX_ROW) + 1,
   parameter int TILE_IDX_W         = (TOTAL_TILE_SOFTMAX > 1) ? $clog2(TOTAL_TILE_SOFTMAX) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          abort,
   input  logic [TOTAL_SOFTMAX_ROW-1:0]  row_done,
   input  logic                          downstream_ready,
   input  logic [TOTAL_TILE_SOFTMAX-1:0] slice_last_r2b,
   output logic [ROW_IDX_W-1:0]          r2b_row_idx,
   output logic [TILE_IDX_W-1:0]         r2b_tile_idx,
   output logic [TOTAL_TILE_SOFTMAX-1:0] in_valid_r2b,
   output logic [TOTAL_TILE_SOFTMAX-1:0] r2b_rst_n,
   output logic                          softmax_rst_n,
   output logic                          busy,
   output logic                          tile_done,
   output logic                          done,
   output logic                          err
);

   import self_attention_pkg::*;

   seq_state_t                    state;
   logic [ROW_IDX_W-1:0]          row;
   logic [TILE_IDX_W-1:0]         tile;
   logic [TOTAL_TILE_SOFTMAX-1:0] tile_onehot;
   logic [TOTAL_TILE_SOFTMAX-1:0] next_onehot;
   logic                          slice_cur;
   logic                          slice_other;
   logic                          row_last;
   logic                          tile_last;

   assign r2b_row_idx  = row;
   assign r2b_tile_idx = tile;

   // Tile decode, slice classification and the unregistered row strobe.
   always_comb begin
      tile_onehot       = '0;
      tile_onehot[tile] = 1'b1;
      next_onehot       = tile_onehot << 1;
      slice_cur         = |(slice_last_r2b & tile_onehot);
      slice_other       = |(slice_last_r2b & ~tile_onehot);
      row_last          = (row == ROW_IDX_W'(TOTAL_SOFTMAX_ROW - 1));
      tile_last         = (tile == TILE_IDX_W'(TOTAL_TILE_SOFTMAX - 1));
      in_valid_r2b      = (state == FEED && downstream_ready) ? tile_onehot : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         row           <= '0;
         tile          <= '0;
         r2b_rst_n     <= '1;
         softmax_rst_n <= 1'b1;
         busy          <= 1'b0;
         tile_done     <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
      end else begin
         tile_done     <= 1'b0;
         done          <= 1'b0;
         r2b_rst_n     <= '1;
         softmax_rst_n <= 1'b1;
         // Abort resets both banks for one cycle and swallows any
         // simultaneous slice or start, so err is left untouched.
         if (abort && state != IDLE) begin
            state         <= IDLE;
            row           <= '0;
            tile          <= '0;
            r2b_rst_n     <= '0;
            softmax_rst_n <= 1'b0;
            busy          <= 1'b0;
         end else begin
            if ((state == FEED && slice_cur) || slice_other || (start && state != IDLE)) begin
               err <= 1'b1;
            end
            case (state)
               IDLE: begin
                  if (start) begin
                     state <= WAIT_ROWS;
                     err   <= 1'b0;
                     tile  <= '0;
                     row   <= '0;
                     busy  <= 1'b1;
                  end
               end
               WAIT_ROWS: begin
                  if (&row_done) begin
                     state     <= RST_R2B;
                     r2b_rst_n <= ~tile_onehot;
                  end
               end
               RST_R2B: begin
                  state <= FEED;
                  row   <= '0;
               end
               FEED: begin
                  if (downstream_ready) begin
                     if (row_last) begin
                        row   <= '0;
                        state <= DRAIN;
                     end else begin
                        row <= row + 1'b1;
                     end
                  end
               end
               DRAIN: begin
                  if (slice_cur) begin
                     tile_done <= 1'b1;
                     if (tile_last) begin
                        state         <= RELEASE;
                        softmax_rst_n <= 1'b0;
                     end else begin
                        tile      <= tile + 1'b1;
                        state     <= RST_R2B;
                        r2b_rst_n <= ~next_onehot;
                     end
                  end
               end
               RELEASE: begin
                  state <= DONE;
                  done  <= 1'b1;
               end
               DONE: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
